// File: rtl/channel_scan_mux_pkg.sv
// channel_scan_mux shared types and helpers.
// Scan mode encoding and a width helper used by every file.
package channel_scan_mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } scan_mode_e;

   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/channel_scan_mux_tick_gen.sv
// scan_tick_gen: divide-by-DIV prescaler for the channel scanner.
// clr restarts the period so the clr cycle itself is count 0.
module scan_tick_gen
   import channel_scan_mux_pkg::*;
#(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cur;

   assign cur  = clr ? '0 : cnt_q;
   assign tick = en & (cur == LAST);

   // Count while enabled, wrapping at the end of each period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cur + CW'(1);
      end else if (clr) begin
         cnt_q <= '0;
      end
   end

endmodule

// File: rtl/channel_scan_mux.sv
// channel_scan_mux: manual/auto-scan channel selector, registered outputs.
// Optional blanking after each auto change: define CHANNEL_SCAN_MUX_BLANK_EN.
module channel_scan_mux
   import channel_scan_mux_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int CHANNELS     = 8,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS*WIDTH-1:0]    data_i,
   input  logic [CHANNELS-1:0]          en_mask_i,
   input  logic                         mode_i,
   input  logic [clog2(CHANNELS)-1:0]   sel_i,
   output logic [WIDTH-1:0]             data_o,
   output logic [clog2(CHANNELS)-1:0]   chan_o,
   output logic [CHANNELS-1:0]          onehot_o,
   output logic                         valid_o
);

   localparam int CW = clog2(CHANNELS);
   localparam logic [CHANNELS-1:0] ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

   scan_mode_e mode;
   logic auto_m;
   logic mode_q;
   logic clr;
   logic tick;
   logic hold;
   logic [CW-1:0] scan_nxt;
   logic [CW-1:0] chan_d;
   logic [WIDTH-1:0] data_d;
   logic [CHANNELS-1:0] onehot_d;
   logic valid_d;

   assign mode   = scan_mode_e'(mode_i);
   assign auto_m = (mode == MODE_AUTO);
   assign clr    = auto_m & ~mode_q;

   // Remember last mode to spot the manual->auto edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_q <= 1'b0;
      else        mode_q <= auto_m;
   end

   scan_tick_gen #(
      .DIV (SCAN_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (auto_m),
      .tick  (tick)
   );

   // Nearest enabled channel above the current one, cyclically.
   always_comb begin
      int idx;
      idx      = 0;
      scan_nxt = chan_o;
      for (int i = CHANNELS; i >= 1; i--) begin
         idx = int'(chan_o) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (en_mask_i[idx]) scan_nxt = CW'(idx);
      end
   end

`ifdef CHANNEL_SCAN_MUX_BLANK_EN
   localparam int BW = clog2(BLANK_CYCLES);
   localparam logic [BW-1:0] BLAST = BW'(BLANK_CYCLES - 1);

   logic [BW-1:0] blank_q;
   logic [BW-1:0] blank_d;
   logic change;

   assign change = auto_m && (|en_mask_i) && tick &&
                   (scan_nxt != chan_o);

   // Hide valid for a fixed window after each auto change.
   always_comb begin
      blank_d = '0;
      hold    = 1'b0;
      if (auto_m) begin
         if (change) begin
            blank_d = BLAST;
            hold    = 1'b1;
         end else if (blank_q != '0) begin
            blank_d = blank_q - BW'(1);
            hold    = 1'b1;
         end
      end
   end

   // Blank window counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blank_q <= '0;
      else        blank_q <= blank_d;
   end
`else
   assign hold = 1'b0;
`endif

   // Next output state for manual select or auto scan.
   always_comb begin
      chan_d  = chan_o;
      data_d  = '0;
      valid_d = 1'b0;
      unique case (1'b1)
         !auto_m: begin
            if (int'(sel_i) < CHANNELS) begin
               chan_d  = sel_i;
               data_d  = data_i[int'(sel_i)*WIDTH +: WIDTH];
               valid_d = 1'b1;
            end
         end
         auto_m && (|en_mask_i): begin
            chan_d  = tick ? scan_nxt : chan_o;
            data_d  = data_i[int'(chan_d)*WIDTH +: WIDTH];
            valid_d = en_mask_i[chan_d] & ~hold;
         end
         default: ;
      endcase
      onehot_d = valid_d ? (ONE << chan_d) : '0;
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan_o   <= '0;
         data_o   <= '0;
         onehot_o <= '0;
         valid_o  <= 1'b0;
      end else begin
         chan_o   <= chan_d;
         data_o   <= data_d;
         onehot_o <= onehot_d;
         valid_o  <= valid_d;
      end
   end

endmodule

// File: tb/tb_channel_scan_mux.sv
// tb_channel_scan_mux: directed plus random checks against a reference model.
// Two instances: 8 channels / div 4 / blank 2, and 6 channels / div 3 / blank 1.
module tb_channel_scan_mux;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mode = 1'b0;

   logic [31:0] data8;
   logic [7:0]  mask8;
   logic [2:0]  sel8;
   logic [3:0]  dout8;
   logic [2:0]  chan8;
   logic [7:0]  oh8;
   logic        v8;

   logic [23:0] data6;
   logic [5:0]  mask6;
   logic [2:0]  sel6;
   logic [3:0]  dout6;
   logic [2:0]  chan6;
   logic [5:0]  oh6;
   logic        v6;

   int total = 0;
   int bad = 0;

`ifdef CHANNEL_SCAN_MUX_BLANK_EN
   localparam bit BLK = 1'b1;
`else
   localparam bit BLK = 1'b0;
`endif

   typedef struct {
      int chan;
      int data;
      int onehot;
      bit valid;
      int pcnt;
      bit mprev;
      int since;
   } mst_t;

   mst_t m8, m6;

   always #5 clk = ~clk;

   channel_scan_mux #(
      .WIDTH(4), .CHANNELS(8), .SCAN_DIV(4), .BLANK_CYCLES(2)
   ) u_dut8 (
      .clk(clk), .rst_n(rst_n), .data_i(data8), .en_mask_i(mask8),
      .mode_i(mode), .sel_i(sel8), .data_o(dout8), .chan_o(chan8),
      .onehot_o(oh8), .valid_o(v8)
   );

   channel_scan_mux #(
      .WIDTH(4), .CHANNELS(6), .SCAN_DIV(3), .BLANK_CYCLES(1)
   ) u_dut6 (
      .clk(clk), .rst_n(rst_n), .data_i(data6), .en_mask_i(mask6),
      .mode_i(mode), .sel_i(sel6), .data_o(dout6), .chan_o(chan6),
      .onehot_o(oh6), .valid_o(v6)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic mst_t rst_st();
      mst_t r;
      r.chan = 0; r.data = 0; r.onehot = 0; r.valid = 0;
      r.pcnt = 0; r.mprev = 0; r.since = 1000;
      return r;
   endfunction

   function automatic mst_t step(mst_t s, int nch, int div, int bl,
                                 logic [31:0] d, logic [31:0] m,
                                 bit md, int sel);
      mst_t r;
      int phase;
      int nxt;
      bit tk;
      bit got;
      r = s;
      if (!md) begin
         r.since = 1000;
         if (sel < nch) begin
            r.chan  = sel;
            r.valid = 1;
            r.data  = int'((d >> (4 * sel)) & 32'hF);
         end else begin
            r.valid = 0;
            r.data  = 0;
         end
      end else begin
         phase  = s.mprev ? s.pcnt : 0;
         tk     = (phase == div - 1);
         r.pcnt = tk ? 0 : phase + 1;
         if (r.since < 1000) r.since++;
         if (m == 0) begin
            r.valid = 0;
            r.data  = 0;
         end else begin
            if (tk) begin
               nxt = s.chan;
               got = 0;
               for (int off = 1; off <= nch; off++) begin
                  if (!got && m[(s.chan + off) % nch]) begin
                     nxt = (s.chan + off) % nch;
                     got = 1;
                  end
               end
               if (nxt != s.chan) r.since = 0;
               r.chan = nxt;
            end
            r.data  = int'((d >> (4 * r.chan)) & 32'hF);
            r.valid = m[r.chan] && (!BLK || r.since >= bl);
         end
      end
      r.mprev  = md;
      r.onehot = r.valid ? (1 << r.chan) : 0;
      return r;
   endfunction

   task automatic cmp_all();
      chk("chan8", chan8, m8.chan);
      chk("valid8", v8, m8.valid);
      chk("oh8", oh8, m8.onehot);
      chk("data8", dout8, m8.data);
      chk("chan6", chan6, m6.chan);
      chk("valid6", v6, m6.valid);
      chk("oh6", oh6, m6.onehot);
      chk("data6", dout6, m6.data);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst_n) begin
         m8 = rst_st();
         m6 = rst_st();
      end else begin
         m8 = step(m8, 8, 4, 2, data8, 32'(mask8), mode, int'(sel8));
         m6 = step(m6, 6, 3, 1, 32'(data6), 32'(mask6), mode,
                   int'(sel6));
      end
      #1;
      cmp_all();
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_d8"}, dout8, 0);
      chk({tag, "_c8"}, chan8, 0);
      chk({tag, "_o8"}, oh8, 0);
      chk({tag, "_v8"}, v8, 0);
      chk({tag, "_d6"}, dout6, 0);
      chk({tag, "_c6"}, chan6, 0);
      chk({tag, "_o6"}, oh6, 0);
      chk({tag, "_v6"}, v6, 0);
   endtask

   initial begin
      int seq[3];
      int ec;
      int ev;
      bit found;
      seq[0] = 1; seq[1] = 4; seq[2] = 7;
      data8 = 32'h76543210;
      data6 = 24'($urandom);
      mask8 = '0; mask6 = '0;
      sel8 = '0; sel6 = '0;
      m8 = rst_st();
      m6 = rst_st();

      #1;
      zero_chk("rst");
      cyc();
      cyc();
      rst_n = 1'b1;

      sel8 = 3'd5; sel6 = 3'd2;
      cyc();
      chk("man_data", dout8, 5);
      chk("man_chan", chan8, 5);
      chk("man_oh", oh8, 32'h20);
      chk("man_valid", v8, 1);

      sel6 = 3'd7;
      cyc();
      chk("oor_valid", v6, 0);
      chk("oor_data", dout6, 0);
      chk("oor_oh", oh6, 0);
      chk("oor_chan", chan6, 2);

      sel8 = 3'd0;
      cyc();

      mask8 = 8'h92; mask6 = 6'b100101; mode = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         ec = (k < 4) ? 0 : seq[((k / 4) - 1) % 3];
         ev = (k < 4) ? 0 : (BLK ? int'((k % 4) >= 2) : 1);
         chk("scan_chan", chan8, ec);
         chk("scan_data", dout8, ec);
         chk("scan_valid", v8, ev);
      end

      rst_n = 1'b0;
      #2;
      m8 = rst_st();
      m6 = rst_st();
      zero_chk("arst");
      cyc();
      cyc();
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k == 3) chk("rr_hold", chan8, 0);
         if (k == 4) chk("rr_adv", chan8, 1);
      end

      mask8 = 8'h00;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("zm_valid", v8, 0);
         chk("zm_data", dout8, 0);
      end
      mask8 = 8'h08;
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
         cyc();
         if (m8.chan == 3) found = 1;
      end
      chk("zm_chan", chan8, 3);
      if (BLK) begin
         cyc();
         cyc();
      end
      chk("zm_resume", v8, 1);

      for (int i = 0; i < 400; i++) begin
         data8 = $urandom;
         data6 = 24'($urandom);
         sel8 = 3'($urandom);
         sel6 = 3'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: begin mask8 = '0; mask6 = '0; end
               1: begin
                  mask8 = 8'(1 << $urandom_range(0, 7));
                  mask6 = 6'(1 << $urandom_range(0, 5));
               end
               default: begin
                  mask8 = 8'($urandom);
                  mask6 = 6'($urandom);
               end
            endcase
         end
         if ($urandom_range(0, 29) == 0) mode = ~mode;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/channel_scan_mux.md
CHANNEL_SCAN_MUX -- requirements
Module: channel_scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of each channel.
REQ-002 SHALL have parameter CHANNELS, default 8, legal 2..32: number of input channels.
REQ-003 SHALL have parameter SCAN_DIV, default 1000, legal >=1: clock cycles per auto-scan step.
REQ-004 SHALL have parameter BLANK_CYCLES, default 4, legal 1..SCAN_DIV-1: blanking length when blanking is compiled in.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset; asynchronous, active-low.
REQ-007 SHALL have port data_i, input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port en_mask_i, input, CHANNELS: bit k=1 means channel k takes part in auto-scan.
REQ-009 SHALL have port mode_i, input, 1: 0 = manual select, 1 = auto-scan.
REQ-010 SHALL have port sel_i, input, clog2(CHANNELS): channel index used in manual mode.
REQ-011 SHALL have port data_o, output, WIDTH: registered data of the current channel.
REQ-012 SHALL have port chan_o, output, clog2(CHANNELS): registered current channel index.
REQ-013 SHALL have port onehot_o, output, CHANNELS: registered one-hot of chan_o, gated by valid_o.
REQ-014 SHALL have port valid_o, output, 1: 1 when data_o/onehot_o carry a live channel.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and pulse tick for one cycle when count==SCAN_DIV-1; SCAN_DIV=1 gives tick every cycle.
REQ-016 Prescaler SHALL run only in auto mode and SHALL clear to 0 on the cycle mode_i goes 0->1.
REQ-017 Manual mode: the cycle after sampling sel_i, chan_o=sel_i, data_o=channel sel_i, valid_o=1; latency is exactly 1 cycle.
REQ-018 Manual mode with sel_i>=CHANNELS SHALL give valid_o=0, data_o=0, onehot_o=0, and chan_o holding its previous value.
REQ-019 Manual mode SHALL ignore en_mask_i.
REQ-020 Auto mode on tick: chan_o SHALL advance to the next index above the current one whose en_mask_i bit is 1, searching cyclically and wrapping CHANNELS-1 -> 0.
REQ-021 Auto mode: if only the current channel is enabled, chan_o SHALL stay unchanged on tick.
REQ-022 Auto mode with en_mask_i all zero: valid_o=0, data_o=0, onehot_o=0, chan_o held; the scan SHALL resume at the next tick after any bit is set.
REQ-023 Auto mode: if the current channel's mask bit clears between ticks, valid_o SHALL drop the next cycle and the channel SHALL advance at the next tick.
REQ-024 On mode switch 1->0, manual behaviour SHALL take effect the next cycle; on 0->1, the scan SHALL start from the current chan_o.
REQ-025 data_o SHALL track data_i of the current channel with 1-cycle latency in both modes, including between ticks.

Reset
REQ-026 While rst_n=0: data_o=0, chan_o=0, onehot_o=0, valid_o=0, prescaler=0, and the blank counter=0, with no clock required.
REQ-027 Reset asserted mid-scan SHALL abort immediately; after release, auto mode SHALL restart from channel 0 with a full SCAN_DIV period before the first tick.

Configuration
REQ-028 Macro CHANNEL_SCAN_MUX_BLANK_EN: when defined, each auto-mode channel change SHALL force valid_o=0 and onehot_o=0 for BLANK_CYCLES cycles, while chan_o and data_o already show the new channel.
REQ-029 Without CHANNEL_SCAN_MUX_BLANK_EN, there SHALL be no blanking, and BLANK_CYCLES SHALL be unused.

Structure
REQ-030 Package channel_scan_mux_pkg SHALL hold the scan-mode enum (MODE_MANUAL=0, MODE_AUTO=1) and the clog2 helper function.
REQ-031 The prescaler SHALL be a sub-module, scan_tick_gen (parameter DIV; ports clk, rst_n, clr, en, tick).

Verification
REQ-032 CHANNELS=8, WIDTH=4, manual, data_i=0x76543210, sel_i=5 -> one cycle later data_o=5, chan_o=5, onehot_o=0x20, valid_o=1.
REQ-033 CHANNELS=6, manual, sel_i=7 -> valid_o=0, data_o=0, onehot_o=0, chan_o unchanged.
REQ-034 Auto, SCAN_DIV=4, en_mask_i=0b10010010 -> chan_o sequence 1,4,7,1 with changes every 4 cycles.
REQ-035 Auto, en_mask_i=0 for 10 cycles, then 0x08 -> valid_o=0 throughout the zero mask; after the next tick, chan_o=3 and valid_o=1.
REQ-036 BLANK_EN defined, BLANK_CYCLES=2, auto -> after each change, valid_o=0 for exactly 2 cycles, then 1.
REQ-037 rst_n pulsed low mid-scan at chan_o=4 -> all outputs 0 asynchronously; after release, the first advance to the next enabled channel occurs SCAN_DIV cycles later.
